// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, DrawX/DrawY scan counters, VGA sync/blank pins
// and a one-cycle frame_start tick. Default timing is 640x480 @ 60 Hz from a 50 MHz Clk.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int SYNC_DLY  = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Enable,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W:0]   DIV_HALF = (DIV_W + 1)'(CLK_DIV / 2);

    // All raster compares are done in 11 bits so totals of exactly 1024 cannot overflow.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Delay-line word is {hs_n, vs_n, blank_n}; idle means both syncs inactive, blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             x_wrap;
    logic             y_wrap;
    logic [2:0]       sync_p [SYNC_DLY+1];

    function automatic logic [2:0] decode(input logic [9:0] x, input logic [9:0] y);
        logic [10:0] xw;
        logic [10:0] yw;
        xw = {1'b0, x};
        yw = {1'b0, y};
        decode = {!((xw >= HS_BEG) && (xw <= HS_END)),
                  !((yw >= VS_BEG) && (yw <= VS_END)),
                  (xw < H_VIS) && (yw < V_VIS)};
    endfunction

    always_comb begin
        pix_en  = Enable && (div == DIV_LAST);
        div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        x_wrap  = ({1'b0, DrawX} == H_LAST);
        y_wrap  = ({1'b0, DrawY} == V_LAST);
        x_nxt   = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt   = DrawY;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div         <= '0;
            VGA_CLK     <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && x_wrap && y_wrap;
            if (Enable) begin
                div     <= div_nxt;
                VGA_CLK <= ({1'b0, div_nxt} >= DIV_HALF);
            end
            if (pix_en) begin
                DrawX <= x_nxt;
                DrawY <= y_nxt;
            end
        end
    end

    // Stage 0 decodes the incoming pixel; stages 1..SYNC_DLY match downstream pixel latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k <= SYNC_DLY; k++) begin
                sync_p[k] <= SYNC_IDLE;
            end
        end else if (pix_en) begin
            sync_p[0] <= decode(x_nxt, y_nxt);
            for (int k = 1; k <= SYNC_DLY; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_p[SYNC_DLY];
    assign VGA_SYNC_N = 1'b0;

endmodule
